// File: rtl/dualrail_onehot_checker.sv
// Dual-rail one-hot checker: validates y/ybar complementarity and one-hot-ness, re-encodes to an index,
// counts bad words and raises a sticky alarm. Optional DRCHK_STALL_ON_ALARM_EN blocks intake while in ALARM.
module dualrail_onehot_checker #(
  parameter int N_OUT        = 16,
  parameter int IDX_W        = 4,
  parameter int ERR_CNT_W    = 8,
  parameter int ALARM_THRESH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N_OUT-1:0]     y,
  input  logic [N_OUT-1:0]     ybar,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IDX_W-1:0]     out_idx,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 alarm,
  input  logic                 clr_alarm
);

  localparam int CONS_W = 4;
  localparam logic [ERR_CNT_W-1:0] ERR_MAX  = '1;
  localparam logic [CONS_W-1:0]    CONS_MAX = '1;
  localparam logic [CONS_W-1:0]    THRESH   = CONS_W'(ALARM_THRESH);

  typedef enum logic [1:0] {
    ST_OK    = 2'd0,
    ST_WARN  = 2'd1,
    ST_ALARM = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic                   r_out_valid;
  logic [IDX_W-1:0]       r_out_idx;
  logic                   r_out_err;
  logic [ERR_CNT_W-1:0]   r_err_cnt;
  logic [ERR_CNT_W-1:0]   w_err_cnt_next;
  logic [CONS_W-1:0]      r_cons;
  logic [CONS_W-1:0]      w_cons_next;

  logic [N_OUT-1:0]       w_rail_eq;
  logic [N_OUT-1:0]       w_y_dec;
  logic                   w_rail_err;
  logic                   w_oh_err;
  logic                   w_bad;
  logic [IDX_W-1:0]       w_idx;
  logic                   w_accept_en;
  logic                   w_accept;
  logic                   w_acc_bad;
  logic                   w_acc_good;
  logic                   w_thresh_hit;

  // Per-bit rail comparison: equal rails on any bit is a rail fault.
  generate
    for (genvar gi = 0; gi < N_OUT; gi++) begin : g_rail
      assign w_rail_eq[gi] = ~(y[gi] ^ ybar[gi]);
    end
  endgenerate

  assign w_rail_err = |w_rail_eq;
  // y & (y-1) clears the lowest set bit; nonzero leftover means more than one bit set.
  assign w_y_dec    = y - N_OUT'(1);
  assign w_oh_err   = (y == '0) || ((y & w_y_dec) != '0);
  assign w_bad      = w_rail_err || w_oh_err;

  always_comb begin
    w_idx = '0;
    for (int i = N_OUT - 1; i >= 0; i--) begin
      if (y[i]) w_idx = IDX_W'(i);
    end
  end

`ifdef DRCHK_STALL_ON_ALARM_EN
  assign w_accept_en = (r_state != ST_ALARM);
`else
  assign w_accept_en = 1'b1;
`endif

  assign in_ready   = (!r_out_valid || out_ready) && w_accept_en;
  assign w_accept   = in_valid && in_ready;
  assign w_acc_bad  = w_accept && w_bad;
  assign w_acc_good = w_accept && !w_bad;

  always_comb begin
    w_err_cnt_next = r_err_cnt;
    w_cons_next    = r_cons;
    if (clr_alarm) begin
      w_err_cnt_next = w_acc_bad ? ERR_CNT_W'(1) : '0;
      w_cons_next    = w_acc_bad ? CONS_W'(1) : '0;
    end else if (w_acc_bad) begin
      if (r_err_cnt != ERR_MAX) w_err_cnt_next = r_err_cnt + ERR_CNT_W'(1);
      if (r_cons != CONS_MAX)   w_cons_next    = r_cons + CONS_W'(1);
    end else if (w_acc_good) begin
      w_cons_next = '0;
    end
  end

  assign w_thresh_hit = (w_cons_next >= THRESH);

  // Clear wins over normal transitions but still honours a bad word accepted on the same edge.
  always_comb begin
    w_state_next = r_state;
    if (clr_alarm) begin
      if (w_acc_bad) w_state_next = w_thresh_hit ? ST_ALARM : ST_WARN;
      else           w_state_next = ST_OK;
    end else if (w_accept) begin
      case (r_state)
        ST_OK: begin
          if (w_bad) w_state_next = w_thresh_hit ? ST_ALARM : ST_WARN;
        end
        ST_WARN: begin
          if (!w_bad)            w_state_next = ST_OK;
          else if (w_thresh_hit) w_state_next = ST_ALARM;
        end
        ST_ALARM: w_state_next = ST_ALARM;
        default:  w_state_next = ST_OK;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_OK;
      r_err_cnt <= '0;
      r_cons    <= '0;
    end else begin
      r_state   <= w_state_next;
      r_err_cnt <= w_err_cnt_next;
      r_cons    <= w_cons_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_idx   <= '0;
      r_out_err   <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_idx   <= w_idx;
      r_out_err   <= w_bad;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_idx   = r_out_idx;
  assign out_err   = r_out_err;
  assign err_count = r_err_cnt;
  assign alarm     = (r_state == ST_ALARM);

endmodule

// File: tb/tb_dualrail_onehot_checker.sv
// Directed bench for dualrail_onehot_checker (default parameters); expectations adapt when
// DRCHK_STALL_ON_ALARM_EN is defined.
module tb_dualrail_onehot_checker;

`ifdef DRCHK_STALL_ON_ALARM_EN
  localparam bit STALL = 1'b1;
`else
  localparam bit STALL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] y;
  logic [15:0] ybar;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_idx;
  logic        out_err;
  logic [7:0]  err_count;
  logic        alarm;
  logic        clr_alarm;

  int total = 0;
  int bad   = 0;

  dualrail_onehot_checker dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y         (y),
    .ybar      (ybar),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_err   (out_err),
    .err_count (err_count),
    .alarm     (alarm),
    .clr_alarm (clr_alarm)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] yv, input logic [15:0] yb);
    in_valid = 1'b1;
    y        = yv;
    ybar     = yb;
    step();
    $display("txn y=%h ybar=%h -> valid=%0d idx=%0d err=%0d cnt=%0d alarm=%0d",
             yv, yb, out_valid, out_idx, out_err, err_count, alarm);
  endtask

  initial begin
    int exp_cnt;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; clr_alarm = 1'b0;
    y = '0; ybar = '0;
    #12;
    check("rst_valid", 32'(out_valid), 0);
    check("rst_idx",   32'(out_idx),   0);
    check("rst_err",   32'(out_err),   0);
    check("rst_cnt",   32'(err_count), 0);
    check("rst_alarm", 32'(alarm),     0);
    check("rst_inrdy", 32'(in_ready),  1);
    @(negedge clk) rst = 1'b0;
    step();

    // 1: good word, one-cycle latency
    send(16'h0020, 16'hFFDF);
    check("t1_valid", 32'(out_valid), 1);
    check("t1_idx",   32'(out_idx),   5);
    check("t1_err",   32'(out_err),   0);
    check("t1_cnt",   32'(err_count), 0);
    check("t1_alarm", 32'(alarm),     0);

    // 2: rail error, then a good word
    send(16'h0020, 16'hFFFF);
    check("t2_err", 32'(out_err),   1);
    check("t2_idx", 32'(out_idx),   5);
    check("t2_cnt", 32'(err_count), 1);
    send(16'h0001, 16'hFFFE);
    check("t2_good_err", 32'(out_err),   0);
    check("t2_good_idx", 32'(out_idx),   0);
    check("t2_good_cnt", 32'(err_count), 1);
    in_valid = 1'b0;
    step(); step();
    check("idle_valid", 32'(out_valid), 0);
    check("idle_cnt",   32'(err_count), 1);

    // 3: four consecutive zero words reach the alarm
    for (int i = 1; i <= 4; i++) begin
      send(16'h0000, 16'hFFFF);
      check("t3_err",   32'(out_err),   1);
      check("t3_cnt",   32'(err_count), 32'(1 + i));
      check("t3_alarm", 32'(alarm),     (i == 4) ? 1 : 0);
    end
    check("t3_inrdy_alarm", 32'(in_ready), STALL ? 0 : 1);
    send(16'h0002, 16'hFFFD);
    check("t3_sticky",      32'(alarm),     1);
    check("t3_sticky_cnt",  32'(err_count), 5);
    check("t3_sticky_valid",32'(out_valid), STALL ? 0 : 1);
    in_valid  = 1'b0;
    clr_alarm = 1'b1;
    step();
    clr_alarm = 1'b0;
    check("t3_clr_alarm", 32'(alarm),     0);
    check("t3_clr_cnt",   32'(err_count), 0);
    check("t3_clr_inrdy", 32'(in_ready),  1);
    // clear together with a bad word leaves one error counted
    clr_alarm = 1'b1;
    send(16'h0000, 16'hFFFF);
    clr_alarm = 1'b0;
    check("t3_clrbad_cnt",   32'(err_count), 1);
    check("t3_clrbad_alarm", 32'(alarm),     0);
    for (int i = 2; i <= 4; i++) begin
      send(16'h0000, 16'hFFFF);
      check("t3_reacc_alarm", 32'(alarm), (i == 4) ? 1 : 0);
    end
    check("t3_reacc_cnt", 32'(err_count), 4);
    in_valid  = 1'b0;
    clr_alarm = 1'b1;
    step();
    clr_alarm = 1'b0;
    check("t3_clr2_alarm", 32'(alarm), 0);

    // 4: backpressure holds the result and keeps the next word
    send(16'h8000, 16'h7FFF);
    check("t4_idx", 32'(out_idx), 15);
    check("t4_err", 32'(out_err), 0);
    out_ready = 1'b0;
    in_valid = 1'b1; y = 16'h0004; ybar = 16'hFFFB;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t4_hold_inrdy", 32'(in_ready),  0);
      check("t4_hold_valid", 32'(out_valid), 1);
      check("t4_hold_idx",   32'(out_idx),   15);
    end
    out_ready = 1'b1;
    #1;
    check("t4_release_inrdy", 32'(in_ready), 1);
    step();
    check("t4_next_valid", 32'(out_valid), 1);
    check("t4_next_idx",   32'(out_idx),   2);
    in_valid = 1'b0;
    step();
    check("t4_drain_valid", 32'(out_valid), 0);
    check("t4_cnt",         32'(err_count), 0);

    // 5: 260 bad words saturate the counter
    for (int i = 1; i <= 260; i++) begin
      send(16'h0C00, 16'hF3FF);
      if (STALL) exp_cnt = (i < 4) ? i : 4;
      else       exp_cnt = (i < 255) ? i : 255;
      check("t5_cnt", 32'(err_count), 32'(exp_cnt));
      if (i == 1) check("t5_idx", 32'(out_idx), 10);
    end
    in_valid  = 1'b0;
    clr_alarm = 1'b1;
    step();
    clr_alarm = 1'b0;
    check("t5_clr_cnt", 32'(err_count), 0);

    // 6: async reset while a word is held under stall
    for (int i = 0; i < 3; i++) send(16'h0000, 16'hFFFF);
    send(16'h0010, 16'hFFFF);
    check("t6_alarm", 32'(alarm),   1);
    check("t6_idx",   32'(out_idx), 4);
    out_ready = 1'b0;
    step();
    check("t6_held_valid", 32'(out_valid), 1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_valid", 32'(out_valid), 0);
    check("t6_rst_alarm", 32'(alarm),     0);
    check("t6_rst_cnt",   32'(err_count), 0);
    check("t6_rst_idx",   32'(out_idx),   0);
    in_valid = 1'b0;
    @(negedge clk) rst = 1'b0;
    step();
    check("t6_after_valid", 32'(out_valid), 0);
    out_ready = 1'b1;
    send(16'h0100, 16'hFEFF);
    check("t6_post_idx",   32'(out_idx),   8);
    check("t6_post_err",   32'(out_err),   0);
    check("t6_post_cnt",   32'(err_count), 0);
    check("t6_post_alarm", 32'(alarm),     0);
    in_valid = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
